// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// host-protocol command/response bytes and the word-count range check.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_WRITE,
        ST_ACK,
        ST_RUN,
        ST_STEP
    } loader_state_e;

    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_PAUSE = 8'h50;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    localparam int LEN_WIDTH = 16;

    // A load is refused when it is empty or holds more words than the memory.
    function automatic logic len_invalid(input logic [LEN_WIDTH-1:0] n,
                                         input int                   addr_width);
        logic [LEN_WIDTH:0] max_words;
        max_words = {{LEN_WIDTH{1'b0}}, 1'b1} << (addr_width - 2);
        return (n == '0) || ({1'b0, n} > max_words);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler: each byte shifts in from the top, so
// after four bytes the first one received sits in bits [7:0].
module byte_packer #(
    parameter int NB_BYTE = 8,
    parameter int NB_WORD = 32
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_valid,
    input  logic [NB_BYTE-1:0] i_byte,
    output logic [NB_WORD-1:0] o_word,
    output logic               o_word_ready
);

    logic [1:0]         count_q, count_d;
    logic [NB_WORD-1:0] word_q, word_d;

    // NOTE: every signal written in a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        count_d = count_q;
        word_d  = word_q;
        if (i_clear) begin
            count_d = '0;
            word_d  = '0;
        end else if (i_valid) begin
            count_d = count_q + 2'd1;
            word_d  = {i_byte, word_q[NB_WORD-1:NB_BYTE]};
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments to avoid simulation races.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            count_q <= '0;
            // NOTE: the partial word is cleared on reset as well, so an aborted load leaves nothing stale.
            word_q  <= '0;
        end else begin
            count_q <= count_d;
            word_q  <= word_d;
        end
    end

    // The completed word is presented in the same cycle as its last byte.
    assign o_word       = word_d;
    assign o_word_ready = i_valid && !i_clear && (count_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// UART-driven instruction-memory loader and run/step controller for the core.
// Every output is a flop whose next value is derived from the next FSM state.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int NB_BYTE         = 8,
    parameter int IMEM_ADDR_WIDTH = 10,
    parameter int IMEM_DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic [NB_BYTE-1:0]         i_rx_data,
    input  logic                       i_rx_valid,
    output logic [NB_BYTE-1:0]         o_tx_data,
    output logic                       o_tx_valid,
    input  logic                       i_tx_ready,
    output logic                       o_imem_wen,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
    output logic [IMEM_DATA_WIDTH-1:0] o_imem_data,
    output logic                       o_cpu_en,
    output logic                       o_cpu_rst,
    input  logic                       i_halt,
    output logic                       o_busy
);

    loader_state_e              state_q, state_d;
    logic [LEN_WIDTH-1:0]       len_q, len_d;
    logic [LEN_WIDTH-1:0]       word_idx_q, word_idx_d;

    logic [NB_BYTE-1:0]         tx_data_q, tx_data_d;
    logic                       tx_valid_q, tx_valid_d;
    logic                       imem_wen_q, imem_wen_d;
    logic [IMEM_ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [IMEM_DATA_WIDTH-1:0] imem_data_q, imem_data_d;
    logic                       cpu_en_q, cpu_en_d;
    logic                       cpu_rst_q, cpu_rst_d;
    logic                       busy_q, busy_d;

    logic [7:0]                 rx_byte;
    logic [LEN_WIDTH-1:0]       len_rx;
    logic                       last_word;
    logic [IMEM_DATA_WIDTH-1:0] packed_word;
    logic                       word_ready;

    assign rx_byte   = i_rx_data[7:0];
    assign len_rx    = {rx_byte, len_q[7:0]};
    assign last_word = (word_idx_q == len_q - LEN_WIDTH'(1));

    // Bytes reach the packer only in DATA, so anything sent during WRITE/ACK is dropped.
    byte_packer #(
        .NB_BYTE (NB_BYTE),
        .NB_WORD (IMEM_DATA_WIDTH)
    ) u_byte_packer (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_clear      (state_q == ST_IDLE),
        .i_valid      (i_rx_valid && (state_q == ST_DATA)),
        .i_byte       (i_rx_data),
        .o_word       (packed_word),
        .o_word_ready (word_ready)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            word_idx_q  <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            imem_wen_q  <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
            cpu_en_q    <= 1'b0;
            cpu_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            imem_wen_q  <= imem_wen_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
            cpu_en_q    <= cpu_en_d;
            cpu_rst_q   <= cpu_rst_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (rx_byte == CMD_LOAD) begin
                        state_d    = ST_LEN_LO;
                        word_idx_d = '0;
                    end else if (rx_byte == CMD_RUN) begin
                        state_d = ST_RUN;
                    end else if (rx_byte == CMD_STEP) begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_LEN_LO: begin
                if (i_rx_valid) begin
                    len_d   = {8'h00, rx_byte};
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (i_rx_valid) begin
                    len_d   = len_rx;
                    state_d = len_invalid(len_rx, IMEM_ADDR_WIDTH) ? ST_ACK : ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_ready) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                word_idx_d = word_idx_q + LEN_WIDTH'(1);
                state_d    = last_word ? ST_ACK : ST_DATA;
            end
            ST_ACK: begin
                if (i_tx_ready) state_d = ST_IDLE;
            end
            ST_RUN: begin
                // Halt and pause in the same cycle collapse into one transition.
                if (i_halt || (i_rx_valid && rx_byte == CMD_PAUSE)) state_d = ST_ACK;
            end
            ST_STEP: state_d = ST_ACK;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_valid_d  = (state_d == ST_ACK);
        tx_data_d   = tx_data_q;
        imem_wen_d  = (state_d == ST_WRITE);
        imem_addr_d = imem_addr_q;
        imem_data_d = imem_data_q;
        cpu_en_d    = (state_d == ST_RUN) || (state_d == ST_STEP);
        busy_d      = (state_d != ST_IDLE);
        cpu_rst_d   = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) ||
                      (state_d == ST_DATA)   || (state_d == ST_WRITE)  ||
                      (state_d == ST_ACK && state_q == ST_WRITE);

        // The response byte is latched on ACK entry and held until accepted.
        if (state_d == ST_ACK && state_q != ST_ACK) begin
            tx_data_d = (state_q == ST_LEN_HI) ? NB_BYTE'(RSP_NAK) : NB_BYTE'(RSP_ACK);
        end
        if (state_d == ST_WRITE) begin
            imem_addr_d = {word_idx_q[IMEM_ADDR_WIDTH-3:0], 2'b00};
            imem_data_d = packed_word;
        end
    end

    assign o_tx_data   = tx_data_q;
    assign o_tx_valid  = tx_valid_q;
    assign o_imem_wen  = imem_wen_q;
    assign o_imem_addr = imem_addr_q;
    assign o_imem_data = imem_data_q;
    assign o_cpu_en    = cpu_en_q;
    assign o_cpu_rst   = cpu_rst_q;
    assign o_busy      = busy_q;

endmodule
